music_recorder: RTL and testbench

Record/playback stage directly downstream of the note-to-code encoder. Each tick it samples the 5-bit music code (0 = rest, 1–21 = low/mid/high notes), run-length encodes it into an internal buffer of (code, duration) entries, and replays that buffer as the same code stream. Its `music_out` feeds the tone generator, muxed with live play outside this block.

---
 rtl/music_recorder_pkg.sv | 14 +
 rtl/music_recorder_tick_gen.sv | 25 ++
 rtl/music_recorder.sv | 172 +++++++++++++++++
 tb/tb_music_recorder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/music_recorder_pkg.sv
// Shared types and constants for the music recorder: state encoding and
// the encoder's code space (5-bit, 0 = rest, notes 1..21).
package music_recorder_pkg;
  localparam int                CODE_W   = 5;
  localparam logic [CODE_W-1:0] REST     = 5'd0;
  localparam logic [CODE_W-1:0] MAX_CODE = 5'd21;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REC       = 2'd1,
    PLAY_LOAD = 2'd2,
    PLAY_HOLD = 2'd3
  } state_e;
endpackage

// File: rtl/music_recorder_tick_gen.sv
// Free-running tick divider; clr holds the count at 0 so the first tick
// lands TICK_CYCLES cycles after clr drops.
module tick_gen #(
  parameter int TICK_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (clr || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick  = !clr && (cnt_q == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/music_recorder.sv
// Run-length record/playback of the encoder code stream: records
// (code, duration) runs per tick and replays them as the same code stream.
module music_recorder
  import music_recorder_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int DUR_W       = 8,
  parameter int TICK_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CODE_W-1:0]          music_in,
  input  logic                       rec_start,
  input  logic                       play_start,
  input  logic                       stop,
  output logic [CODE_W-1:0]          music_out,
  output logic                       recording,
  output logic                       playing,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     entries
);
  localparam int               AW      = $clog2(DEPTH);
  localparam int               EW      = AW + 1;
  localparam logic [EW-1:0]    LAST    = EW'(DEPTH - 1);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  state_e              state_q, state_d;
  logic [EW-1:0]       entries_q, entries_d;
  logic                full_q, full_d;
  logic [CODE_W-1:0]   run_code_q, run_code_d;
  logic [DUR_W-1:0]    run_dur_q, run_dur_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DUR_W-1:0]    hold_q, hold_d;
  logic [CODE_W-1:0]   music_out_q, music_out_d;
  logic                recording_q, recording_d;
  logic                playing_q, playing_d;

  logic [CODE_W+DUR_W-1:0] mem_q [DEPTH];
  logic                    wr_en;
  logic [CODE_W+DUR_W-1:0] wr_data;
  logic                    tick, tick_clr;

  // Counter is held cleared outside the two timed states, so it restarts on entry.
  assign tick_clr = !(state_q == REC || state_q == PLAY_HOLD);

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  always_comb begin
    state_d     = state_q;
    entries_d   = entries_q;
    full_d      = full_q;
    run_code_d  = run_code_q;
    run_dur_d   = run_dur_q;
    rd_ptr_d    = rd_ptr_q;
    hold_d      = hold_q;
    music_out_d = music_out_q;
    wr_en       = 1'b0;
    wr_data     = {run_code_q, run_dur_q};
    case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (rec_start) begin
          entries_d  = '0;
          full_d     = 1'b0;
          run_code_d = music_in;
          run_dur_d  = '0;
          state_d    = REC;
        end else if (play_start && entries_q != '0) begin
          rd_ptr_d = '0;
          state_d  = PLAY_LOAD;
        end
      end
      REC: begin
        if (stop) begin
          if (run_dur_q != '0 && !full_q) begin
            wr_en     = 1'b1;
            entries_d = entries_q + EW'(1);
            full_d    = (entries_q == LAST);
          end
          state_d = IDLE;
        end else if (tick) begin
          if (music_in == run_code_q && run_dur_q != DUR_MAX) begin
            run_dur_d = run_dur_q + DUR_W'(1);
          end else begin
            run_code_d = music_in;
            run_dur_d  = DUR_W'(1);
            if (run_dur_q != '0) begin
              wr_en     = 1'b1;
              entries_d = entries_q + EW'(1);
              // Filling the last slot ends the take; the run just started is lost.
              if (entries_q == LAST) begin
                full_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
      end
      PLAY_LOAD: begin
        if (stop) begin
          music_out_d = REST;
          state_d     = IDLE;
        end else begin
          {music_out_d, hold_d} = mem_q[rd_ptr_q];
          state_d               = PLAY_HOLD;
        end
      end
      PLAY_HOLD: begin
        if (stop) begin
          music_out_d = REST;
          state_d     = IDLE;
        end else if (tick) begin
          hold_d = hold_q - DUR_W'(1);
          if (hold_q == DUR_W'(1)) begin
            if ({1'b0, rd_ptr_q} + EW'(1) < entries_q) begin
              rd_ptr_d = rd_ptr_q + AW'(1);
              state_d  = PLAY_LOAD;
            end else begin
              music_out_d = REST;
              state_d     = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    recording_d = (state_d == REC);
    playing_d   = (state_d == PLAY_LOAD) || (state_d == PLAY_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      entries_q   <= '0;
      full_q      <= 1'b0;
      run_code_q  <= REST;
      run_dur_q   <= '0;
      rd_ptr_q    <= '0;
      hold_q      <= '0;
      music_out_q <= REST;
      recording_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      entries_q   <= entries_d;
      full_q      <= full_d;
      run_code_q  <= run_code_d;
      run_dur_q   <= run_dur_d;
      rd_ptr_q    <= rd_ptr_d;
      hold_q      <= hold_d;
      music_out_q <= music_out_d;
      recording_q <= recording_d;
      playing_q   <= playing_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[entries_q[AW-1:0]] <= wr_data;
  end

  assign music_out = music_out_q;
  assign recording = recording_q;
  assign playing   = playing_q;
  assign full      = full_q;
  assign entries   = entries_q;
endmodule

// File: tb/tb_music_recorder.sv
// Directed bench for music_recorder with a 4-cycle tick, 4-entry buffer
// and 3-bit durations; expected values are worked out by hand.
module tb_music_recorder;
  localparam int DEPTH = 4;
  localparam int DUR_W = 3;
  localparam int TICK  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
  logic [4:0] music_in = 5'd0;
  logic [4:0] music_out;
  logic       recording, playing, full;
  logic [2:0] entries;

  int errors = 0;
  int checks = 0;

  music_recorder #(.DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_CYCLES(TICK)) dut (
    .clk       (clk),
    .rst       (rst),
    .music_in  (music_in),
    .rec_start (rec_start),
    .play_start(play_start),
    .stop      (stop),
    .music_out (music_out),
    .recording (recording),
    .playing   (playing),
    .full      (full),
    .entries   (entries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic r, input logic p);
    stop = s; rec_start = r; play_start = p;
    @(negedge clk);
    stop = 1'b0; rec_start = 1'b0; play_start = 1'b0;
  endtask

  task automatic hold(input logic [4:0] c, input int ticks);
    music_in = c;
    cyc(TICK * ticks);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_out"},  music_out, 0);
    chk({tag, "_rec"},  recording, 0);
    chk({tag, "_play"}, playing,   0);
    chk({tag, "_full"}, full,      0);
    chk({tag, "_ent"},  entries,   0);
  endtask

  initial begin
    logic [4:0] exp_code;
    // Reset state
    #12;
    chk_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc(1);

    // stop beats rec_start; play with empty buffer is ignored
    pulse(1'b1, 1'b1, 1'b0);
    chk("prio_rec", recording, 0);
    cyc(1);
    chk("prio_rec2", recording, 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("empty_play", playing, 0);
    cyc(1);
    chk("empty_play2", playing, 0);

    // Basic record: 8 x3, rest x2, 15 x1
    music_in = 5'd8;
    pulse(1'b0, 1'b1, 1'b0);
    chk("rec_on", recording, 1);
    chk("rec_out", music_out, 0);
    hold(5'd8, 3);
    hold(5'd0, 2);
    hold(5'd15, 1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("basic_entries", entries, 3);
    chk("basic_rec_off", recording, 0);
    chk("basic_full", full, 0);
    music_in = 5'd0;

    // Basic playback, sampled every cycle
    pulse(1'b0, 1'b0, 1'b1);
    chk("play_load", playing, 1);
    chk("play_load_out", music_out, 0);
    for (int k = 1; k <= 27; k++) begin
      cyc(1);
      exp_code = (k <= 13) ? 5'd8 : (k <= 22) ? 5'd0 : (k <= 26) ? 5'd15 : 5'd0;
      chk("play_basic_out", music_out, exp_code);
      chk("play_basic_playing", playing, (k < 27) ? 1 : 0);
    end

    // Stop during the second entry, then restart from entry 0
    pulse(1'b0, 1'b0, 1'b1);
    cyc(15);
    pulse(1'b1, 1'b0, 1'b0);
    chk("stop_out", music_out, 0);
    chk("stop_playing", playing, 0);
    pulse(1'b0, 1'b0, 1'b1);
    cyc(1);
    chk("restart_out", music_out, 8);
    cyc(12);
    chk("restart_out13", music_out, 8);
    cyc(1);
    chk("restart_out14", music_out, 0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("restart_stop", playing, 0);

    // Saturation: 9 ticks of code 5 splits into {5,7},{5,2}
    music_in = 5'd5;
    pulse(1'b0, 1'b1, 1'b0);
    hold(5'd5, 9);
    pulse(1'b1, 1'b0, 1'b0);
    chk("sat_entries", entries, 2);
    music_in = 5'd0;
    pulse(1'b0, 1'b0, 1'b1);
    cyc(1);
    chk("sat_out1", music_out, 5);
    cyc(36);
    chk("sat_out37", music_out, 5);
    chk("sat_play37", playing, 1);
    cyc(1);
    chk("sat_out38", music_out, 0);
    chk("sat_play38", playing, 0);

    // Overflow: five 1-tick runs, the fifth is dropped
    music_in = 5'd3;
    pulse(1'b0, 1'b1, 1'b0);
    hold(5'd3, 1);
    hold(5'd21, 1);
    hold(5'd0, 1);
    hold(5'd9, 1);
    hold(5'd17, 1);
    chk("ovf_full", full, 1);
    chk("ovf_entries", entries, 4);
    chk("ovf_rec", recording, 0);
    music_in = 5'd0;
    pulse(1'b0, 1'b0, 1'b1);
    cyc(1);  chk("ovf_e0", music_out, 3);
    cyc(4);  chk("ovf_e0_end", music_out, 3);
    cyc(1);  chk("ovf_e1", music_out, 21);
    cyc(5);  chk("ovf_e2", music_out, 0);
    cyc(5);  chk("ovf_e3", music_out, 9);
    cyc(3);  chk("ovf_e3_end", music_out, 9);
    cyc(1);  chk("ovf_done", music_out, 0);
    chk("ovf_done_play", playing, 0);

    // New recording clears full; then async reset mid-record
    music_in = 5'd7;
    pulse(1'b0, 1'b1, 1'b0);
    chk("rerec_full", full, 0);
    chk("rerec_entries", entries, 0);
    chk("rerec_rec", recording, 1);
    hold(5'd7, 1);
    hold(5'd9, 1);
    chk("rerec_commit", entries, 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("post_rst_play", playing, 0);
    cyc(1);
    chk("post_rst_play2", playing, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
